// File: rtl/fir_pix_sink.sv
// fir_pix_sink: drops FIR fill samples, scales/clamps to 8-bit pixels, tags raster position, per-frame sum/clamp stats.
// Latency: 1 clock from an accepted sample to pix_out; all outputs registered. Optional rounding: FIR_PIX_SINK_ROUND_EN.
// Backpressure: none upstream; en low stalls every counter and accumulator, and pix_valid drops on the next cycle.
module fir_pix_sink #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 8,
    parameter int SHIFT = 2,
    parameter int SKIP  = 7,
    parameter int COLS  = 512,
    parameter int ROWS  = 512
) (
    input  logic                      clk,
    input  logic                      nReset,
    input  logic                      en,
    input  logic [IN_W-1:0]           Y_in,
    output logic [OUT_W-1:0]          pix_out,
    output logic                      pix_valid,
    output logic                      sol,
    output logic                      eol,
    output logic                      eof,
    output logic [$clog2(COLS)-1:0]   col,
    output logic [$clog2(ROWS)-1:0]   row,
    output logic [31:0]               frame_sum,
    output logic [15:0]               sat_cnt,
    output logic                      sum_valid,
    output logic                      busy
);

    localparam int CW  = $clog2(COLS);
    localparam int RW  = $clog2(ROWS);
    localparam int SKW = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam logic signed [IN_W:0] PIX_MAX = (IN_W+1)'((1 << OUT_W) - 1);

    typedef enum logic {
        ST_SKIP   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    localparam state_t ST_RST = (SKIP > 0) ? ST_SKIP : ST_STREAM;

    state_t           state_q, state_d;
    logic [SKW-1:0]   skip_cnt_q, skip_cnt_d;
    logic [CW-1:0]    col_q;
    logic [RW-1:0]    row_q;
    logic [31:0]      acc_sum_q;
    logic [15:0]      acc_sat_q;
    logic [15:0]      sat_next;
    logic             accept;
    logic             at_eol;
    logic             at_eof;

    logic signed [IN_W:0] y_ext;
    logic signed [IN_W:0] y_rnd;
    logic signed [IN_W:0] s;
    logic [OUT_W-1:0]     pix_d;
    logic                 clamp_d;

    // One extra bit of headroom so rounding 0x7FF cannot wrap negative.
    always_comb begin
        y_ext = {Y_in[IN_W-1], Y_in};
`ifdef FIR_PIX_SINK_ROUND_EN
        if (SHIFT > 0) begin
            y_rnd = y_ext + (IN_W+1)'(1 << ((SHIFT > 0) ? SHIFT - 1 : 0));
        end else begin
            y_rnd = y_ext;
        end
`else
        y_rnd = y_ext;
`endif
        s       = y_rnd >>> SHIFT;
        pix_d   = s[OUT_W-1:0];
        clamp_d = 1'b0;
        if (s < 0) begin
            pix_d   = '0;
            clamp_d = 1'b1;
        end else if (s > PIX_MAX) begin
            pix_d   = '1;
            clamp_d = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        if (en && (state_q == ST_SKIP)) begin
            if (skip_cnt_q == SKW'(SKIP - 1)) begin
                state_d    = ST_STREAM;
                skip_cnt_d = '0;
            end else begin
                skip_cnt_d = skip_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= ST_RST;
            skip_cnt_q <= '0;
            busy       <= (SKIP > 0);
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
            busy       <= (state_d == ST_SKIP);
        end
    end

    assign accept   = en && (state_q == ST_STREAM);
    assign at_eol   = (col_q == CW'(COLS - 1));
    assign at_eof   = at_eol && (row_q == RW'(ROWS - 1));
    assign sat_next = (clamp_d && (acc_sat_q != 16'hFFFF)) ? acc_sat_q + 16'd1 : acc_sat_q;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            pix_out   <= '0;
            pix_valid <= 1'b0;
            sol       <= 1'b0;
            eol       <= 1'b0;
            eof       <= 1'b0;
            col       <= '0;
            row       <= '0;
            frame_sum <= '0;
            sat_cnt   <= '0;
            sum_valid <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            acc_sum_q <= '0;
            acc_sat_q <= '0;
        end else begin
            pix_valid <= accept;
            sum_valid <= 1'b0;
            if (accept) begin
                pix_out <= pix_d;
                col     <= col_q;
                row     <= row_q;
                sol     <= (col_q == '0);
                eol     <= at_eol;
                eof     <= at_eof;
                if (at_eol) begin
                    col_q <= '0;
                    row_q <= at_eof ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
                // The eof pixel itself is folded into the published totals.
                if (at_eof) begin
                    frame_sum <= acc_sum_q + 32'(pix_d);
                    sat_cnt   <= sat_next;
                    sum_valid <= 1'b1;
                    acc_sum_q <= '0;
                    acc_sat_q <= '0;
                end else begin
                    acc_sum_q <= acc_sum_q + 32'(pix_d);
                    acc_sat_q <= sat_next;
                end
            end
        end
    end

endmodule
